decryption_cfg_arbiter: RTL
===========================

Name: decryption_cfg_arbiter

Overview:
Two-master arbiter and sequencer for the decryption register file's single access port (addr/read/write/wdata -> rdata/done/error).
- Master 0: host configuration interface.
- Master 1: on-chip key loader.
- Grants one transaction at a time using round-robin, drives the register-file strobes, waits for done, and returns rdata/error to the granted master.
- Converts a missing done into a timeout error and rejects malformed commands locally.

Parameters:
ADDR_WIDTH, 8, register address width (matches register file).
DATA_WIDTH, 16, register data width.
TIMEOUT, 15, max cycles in WAIT before the access is aborted with error.
TO_WIDTH, 4, timeout counter width; must hold TIMEOUT.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
m0_req / m1_req  in  1  request; held high with command stable until ack.
m0_addr / m1_addr  in  ADDR_WIDTH  register address.
m0_read / m1_read  in  1  read command.
m0_write / m1_write  in  1  write command.
m0_wdata / m1_wdata  in  DATA_WIDTH  write data.
m0_ack / m1_ack  out  1  one-cycle completion pulse.
m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid while ack high.
m0_error / m1_error  out  1  error status, valid while ack high.
rf_addr  out  ADDR_WIDTH  to register file.
rf_read  out  1  to register file.
rf_write  out  1  to register file.
rf_wdata  out  DATA_WIDTH  to register file.
rf_rdata  in  DATA_WIDTH  from register file.
rf_done  in  1  from register file.
rf_error  in  1  from register file.
busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs registered.
- Reset (rst_n=0 at a clock edge): state=IDLE, all outputs 0, counter=0, last_grant=1 (so m0 wins the first contention). Reset mid-transaction aborts it silently; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample reqs. If only one is high, grant it. If both are high, grant the master not equal to last_grant. Update last_grant.
  - Latch the granted master's addr/read/write/wdata.
  - If exactly one of read/write is set, go to ISSUE.
  - Otherwise (both or neither set), go to RESP with error=1 and rdata=0; register file is not touched.
- ISSUE (1 cycle):
  - rf_read/rf_write = latched command for exactly this cycle.
  - rf_addr/rf_wdata = latched values, held through WAIT.
  - Clear counter; go to WAIT.
- WAIT:
  - rf_read=rf_write=0.
  - On rf_done=1: capture rf_rdata and rf_error; go to RESP.
  - Else increment counter. When counter==TIMEOUT, go to RESP with error=1 and rdata=0.
  - rf_done arriving outside WAIT is ignored.
- RESP (1 cycle):
  - Granted master's ack=1 with captured rdata/error; the other master's outputs stay 0.
  - Go to IDLE.
  - In the cycle after RESP: ack=0 and rdata/error cleared to 0.
- Master handshake rule: the master drops req at the clock edge that samples ack, so req is low in the following IDLE cycle.
- Nominal latency, with req sampled in IDLE cycle T and the register file answering done one cycle after its strobe:
  - rf strobe in T+1
  - rf_done in T+2
  - ack in T+3
  - Next grant sampled in T+4 at the earliest.
- Fairness: with both reqs held continuously, grants alternate m0, m1, m0, ...
- A req rising while busy waits; it is sampled in the next IDLE cycle.
- Writes are forwarded unmodified; any address filtering is left to the register file's error response.

Test Plan:
- Reset, then m0 writes addr 0x10, wdata 0x0003 -> rf_write=1 one cycle with rf_addr=0x10, rf_wdata=0x0003; m0_ack pulse 3 cycles after grant with m0_error=0; m1_ack stays 0.
- m1 reads addr 0x14, register file returns 0x0002 -> m1_ack with m1_rdata=0x0002, m1_error=0; busy high from ISSUE through RESP.
- m0 and m1 request in the same cycle, both held for 4 transactions -> grant order m0, m1, m0, m1; no rf strobe overlap; acks 4 cycles apart.
- m0 accesses addr 0x20 and the register file answers with rf_error=1 -> m0_ack with m0_error=1.
- m1 issues read=write=1 -> m1_ack on the cycle after grant with error=1; rf_read/rf_write never asserted.
- rf_done tied low -> ack with error=1, rdata=0 after TIMEOUT=15 WAIT cycles. Separately, rst_n=0 during WAIT -> no ack, all outputs 0, busy=0.

Source files
------------

// File: rtl/decryption_cfg_arbiter.sv
// ----------------------------------------------------------------------------
// decryption_cfg_arbiter
//
// Arbitrates the decryption register file's single access port between two
// masters: the host configuration interface (m0) and the on-chip key loader
// (m1). One transaction is in flight at a time. Contention is resolved
// round-robin. The arbiter drives the register-file strobe for one cycle and
// then waits for done. The response goes back to the granted master as a
// one-cycle ack.
//
// Error responses:
//   - A command with both or neither of read/write set is answered locally
//     with error=1, rdata=0. The register file is not touched.
//   - A register file that never answers is cut off after TIMEOUT wait
//     cycles. That access is answered with error=1, rdata=0.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   i_mN_req            request, held with a stable command until ack
//   i_mN_addr/read/     command from master N
//   write/wdata
//   o_mN_ack            one-cycle completion pulse
//   o_mN_rdata/error    response, valid while ack is high, 0 otherwise
//   o_rf_addr/read/     register-file access port (read/write are strobes)
//   write/wdata
//   i_rf_rdata/done/    register-file response
//   error
//   o_busy              high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module decryption_cfg_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 15,
   parameter int TO_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_m0_req,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic                  i_m0_read,
   input  logic                  i_m0_write,
   input  logic [DATA_WIDTH-1:0] i_m0_wdata,
   output logic                  o_m0_ack,
   output logic [DATA_WIDTH-1:0] o_m0_rdata,
   output logic                  o_m0_error,
   input  logic                  i_m1_req,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic                  i_m1_read,
   input  logic                  i_m1_write,
   input  logic [DATA_WIDTH-1:0] i_m1_wdata,
   output logic                  o_m1_ack,
   output logic [DATA_WIDTH-1:0] o_m1_rdata,
   output logic                  o_m1_error,
   output logic [ADDR_WIDTH-1:0] o_rf_addr,
   output logic                  o_rf_read,
   output logic                  o_rf_write,
   output logic [DATA_WIDTH-1:0] o_rf_wdata,
   input  logic [DATA_WIDTH-1:0] i_rf_rdata,
   input  logic                  i_rf_done,
   input  logic                  i_rf_error,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [TO_WIDTH-1:0] TIMEOUT_CNT = TO_WIDTH'(TIMEOUT);
   localparam logic [TO_WIDTH-1:0] CNT_ONE     = {{(TO_WIDTH-1){1'b0}}, 1'b1};

   // Sequencer context. A grant value of 0 means m0 and 1 means m1.
   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_last_grant;
   logic                w_last_grant_nxt;
   logic                r_grant;
   logic                w_grant_nxt;
   logic [TO_WIDTH-1:0] r_cnt;
   logic [TO_WIDTH-1:0] w_cnt_nxt;
   logic [TO_WIDTH-1:0] w_cnt_inc;

   // Registered outputs
   logic                  r_m0_ack;
   logic [DATA_WIDTH-1:0] r_m0_rdata;
   logic                  r_m0_error;
   logic                  r_m1_ack;
   logic [DATA_WIDTH-1:0] r_m1_rdata;
   logic                  r_m1_error;
   logic [ADDR_WIDTH-1:0] r_rf_addr;
   logic                  r_rf_read;
   logic                  r_rf_write;
   logic [DATA_WIDTH-1:0] r_rf_wdata;
   logic                  r_busy;

   // Next values for the register-file side and the response
   logic [ADDR_WIDTH-1:0] w_rf_addr_nxt;
   logic [DATA_WIDTH-1:0] w_rf_wdata_nxt;
   logic                  w_rf_read_nxt;
   logic                  w_rf_write_nxt;
   logic                  w_resp_valid;
   logic [DATA_WIDTH-1:0] w_resp_rdata;
   logic                  w_resp_error;
   logic                  w_resp_m0;
   logic                  w_resp_m1;

   // Command of the master that would be granted in this IDLE cycle
   logic                  w_pick;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic                  w_sel_read;
   logic                  w_sel_write;
   logic [DATA_WIDTH-1:0] w_sel_wdata;

   // Round-robin choice: a contended grant goes to the master served less recently
   always_comb begin
      if (i_m0_req && i_m1_req) begin
         w_pick = ~r_last_grant;
      end else if (i_m1_req) begin
         w_pick = 1'b1;
      end else begin
         w_pick = 1'b0;
      end
   end

   assign w_sel_addr  = w_pick ? i_m1_addr  : i_m0_addr;
   assign w_sel_read  = w_pick ? i_m1_read  : i_m0_read;
   assign w_sel_write = w_pick ? i_m1_write : i_m0_write;
   assign w_sel_wdata = w_pick ? i_m1_wdata : i_m0_wdata;
   assign w_cnt_inc   = r_cnt + CNT_ONE;

   // Next-state and next-output logic of the access sequencer
   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      w_grant_nxt      = r_grant;
      w_cnt_nxt        = r_cnt;
      w_rf_addr_nxt    = r_rf_addr;
      w_rf_wdata_nxt   = r_rf_wdata;
      w_rf_read_nxt    = 1'b0;
      w_rf_write_nxt   = 1'b0;
      w_resp_valid     = 1'b0;
      w_resp_rdata     = {DATA_WIDTH{1'b0}};
      w_resp_error     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_m0_req || i_m1_req) begin
               w_grant_nxt      = w_pick;
               w_last_grant_nxt = w_pick;
               if (w_sel_read ^ w_sel_write) begin
                  // Strobe and address are registered here so they are
                  // presented to the register file during ISSUE.
                  w_state_nxt    = ST_ISSUE;
                  w_rf_addr_nxt  = w_sel_addr;
                  w_rf_wdata_nxt = w_sel_wdata;
                  w_rf_read_nxt  = w_sel_read;
                  w_rf_write_nxt = w_sel_write;
               end else begin
                  // Malformed command: answer locally, register file untouched
                  w_state_nxt  = ST_RESP;
                  w_resp_valid = 1'b1;
                  w_resp_error = 1'b1;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            w_cnt_nxt   = {TO_WIDTH{1'b0}};
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_rf_done) begin
               w_state_nxt  = ST_RESP;
               w_resp_valid = 1'b1;
               w_resp_rdata = i_rf_rdata;
               w_resp_error = i_rf_error;
            end else if (w_cnt_inc == TIMEOUT_CNT) begin
               // Give up after TIMEOUT wait cycles without done
               w_state_nxt  = ST_RESP;
               w_resp_valid = 1'b1;
               w_resp_error = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_resp_m0 = w_resp_valid & ~w_grant_nxt;
   assign w_resp_m1 = w_resp_valid &  w_grant_nxt;

   // Sequencer state register; last_grant resets to m1 so m0 wins first contention
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_cnt        <= {TO_WIDTH{1'b0}};
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_grant      <= w_grant_nxt;
         r_cnt        <= w_cnt_nxt;
      end
   end

   // Output registers; the response reaches only the granted master
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_m0_ack   <= 1'b0;
         r_m0_rdata <= {DATA_WIDTH{1'b0}};
         r_m0_error <= 1'b0;
         r_m1_ack   <= 1'b0;
         r_m1_rdata <= {DATA_WIDTH{1'b0}};
         r_m1_error <= 1'b0;
         r_rf_addr  <= {ADDR_WIDTH{1'b0}};
         r_rf_read  <= 1'b0;
         r_rf_write <= 1'b0;
         r_rf_wdata <= {DATA_WIDTH{1'b0}};
         r_busy     <= 1'b0;
      end else begin
         r_m0_ack   <= w_resp_m0;
         r_m0_rdata <= w_resp_m0 ? w_resp_rdata : {DATA_WIDTH{1'b0}};
         r_m0_error <= w_resp_m0 & w_resp_error;
         r_m1_ack   <= w_resp_m1;
         r_m1_rdata <= w_resp_m1 ? w_resp_rdata : {DATA_WIDTH{1'b0}};
         r_m1_error <= w_resp_m1 & w_resp_error;
         r_rf_addr  <= w_rf_addr_nxt;
         r_rf_read  <= w_rf_read_nxt;
         r_rf_write <= w_rf_write_nxt;
         r_rf_wdata <= w_rf_wdata_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
      end
   end

   assign o_m0_ack   = r_m0_ack;
   assign o_m0_rdata = r_m0_rdata;
   assign o_m0_error = r_m0_error;
   assign o_m1_ack   = r_m1_ack;
   assign o_m1_rdata = r_m1_rdata;
   assign o_m1_error = r_m1_error;
   assign o_rf_addr  = r_rf_addr;
   assign o_rf_read  = r_rf_read;
   assign o_rf_write = r_rf_write;
   assign o_rf_wdata = r_rf_wdata;
   assign o_busy     = r_busy;

endmodule
